mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequential arbiter for the single byte-wide SDRAM port (sram block).
- Shares the port between three requesters:
  - the loader (ioctl write stream);
  - the FDD buffer reader (wd1793 image fetch);
  - the CPU (k580vm80a read/write).
- Replaces the combinational address/data mux in the top level.
- Provides a CPU ready line that stalls the CPU via pin_ready while its access is pending.

Parameters:
- MEM_LAT, 4: clock cycles from issue strobe until mem_dout is valid. Legal range 1..15.
- FDD_BASE, 5'b00001: upper 5 address bits prepended to fdd_addr to form the 25-bit address.
- STARVE_MAX, 4: consecutive non-CPU grants tolerated while cpu_req is pending. Used only with ARB_STARVE_GUARD_EN.

Ports:
- clk_sys  in  1  system clock, 48 MHz.
- reset_n  in  1  asynchronous reset, active-low.
- ld_req  in  1  loader write request (level).
- ld_addr  in  25  loader address.
- ld_data  in  8  loader write data.
- ld_ack  out  1  one-cycle pulse when the loader write has completed.
- fdd_req  in  1  FDD buffer read request (level).
- fdd_addr  in  20  FDD buffer byte address.
- fdd_data  out  8  registered FDD read data.
- fdd_ack  out  1  one-cycle pulse; fdd_data is valid from this cycle.
- cpu_req  in  1  CPU access request (level).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  25  CPU physical address (after page mapping).
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  registered CPU read data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_ready  out  1  CPU stall line, low while a CPU access is pending.
- mem_addr  out  25  SDRAM address.
- mem_din  out  8  SDRAM write data.
- mem_we  out  1  one-cycle write strobe.
- mem_rd  out  1  one-cycle read strobe.
- mem_dout  in  8  SDRAM read data.

Behaviour:
- Clock and reset:
  - Single clock domain, clk_sys.
  - reset_n is asynchronous and active-low.
  - Reset values: FSM=IDLE; mem_addr=0; mem_din=0; mem_we=0; mem_rd=0; all acks=0; fdd_data=0; cpu_rdata=0; grant register cleared; starve counter=0.
  - Reset asserted mid-access aborts the access immediately. No ack is issued for it.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: samples requests. Fixed priority is ld > fdd > cpu. The winner is latched into the grant register along with its address and data. Go to ISSUE if any request is present, otherwise stay in IDLE.
  - ISSUE:
    - Drive mem_addr from the granted source. For FDD this is {FDD_BASE, fdd_addr}.
    - Drive mem_din for writes.
    - Pulse mem_we (loader, or CPU with cpu_we=1) or mem_rd (FDD, or CPU with cpu_we=0) for exactly one cycle.
    - Go to WAIT if MEM_LAT>1, otherwise go to DONE.
  - WAIT: hold mem_addr and mem_din; strobes low. Stay for MEM_LAT-1 cycles, using a 4-bit down-counter, then go to DONE.
  - DONE:
    - For reads, capture mem_dout into fdd_data or cpu_rdata.
    - Pulse the matching ack for one cycle.
    - Return to IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0; ISSUE at cycle 1; ack at cycle MEM_LAT+1.
  - Minimum spacing between grants is MEM_LAT+2 cycles.
- Handshake:
  - The requester holds req until it sees ack. It deasserts req in the cycle after ack; if req is still high in the next IDLE, that is a new request.
  - req dropped mid-access: the access completes and ack still pulses.
  - The address/data inputs are not re-sampled after IDLE.
  - A higher-priority request arriving mid-access waits for IDLE. There is no preemption.
- Read data: fdd_data and cpu_rdata hold their value until the next read completes for that source.
- cpu_ready is combinational: cpu_ready = ~cpu_req | cpu_ack. It is high whenever there is no CPU request.
- Simultaneous requests: ld+fdd+cpu in the same IDLE cycle are granted in the order ld, then fdd, then cpu, on successive IDLE visits, provided all three requests stay asserted.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- When defined:
  - A 4-bit counter increments on each ld or fdd grant made while cpu_req is high.
  - The counter clears on a CPU grant, or in any cycle with cpu_req low.
  - When the counter equals STARVE_MAX, the next IDLE grants the CPU regardless of ld_req or fdd_req.
- When undefined: strict fixed priority; counter logic is absent.

Test Plan:
1. Reset release, CPU read only: cpu_req=1, cpu_we=0, cpu_addr=25'h00C123, mem_dout=8'h5A at DONE (MEM_LAT=4) -> mem_rd pulses at cycle 1 with mem_addr=25'h00C123; cpu_ack and cpu_rdata=8'h5A at cycle 5; cpu_ready low in cycles 0-4 and high at cycle 5.
2. Loader write: ld_addr=25'h000100, ld_data=8'hC3 -> mem_we pulses once with mem_addr=25'h000100 and mem_din=8'hC3; ld_ack at cycle 5; mem_rd never asserts.
3. FDD read: fdd_addr=20'h00010 -> mem_addr=25'h0100010; fdd_data latched from mem_dout; fdd_ack is a single pulse.
4. ld, fdd and cpu requests all asserted in the same cycle and held -> grants in order ld, fdd, cpu; ack pulses at cycles 5, 11 and 17.
5. reset_n asserted low during WAIT of a CPU read -> all strobes and acks go to 0 asynchronously; after release FSM is IDLE and no stale cpu_ack appears.
6. With ARB_STARVE_GUARD_EN and STARVE_MAX=4: fdd_req and cpu_req held continuously -> four FDD grants, then a CPU grant, then FDD resumes. Without the macro -> the CPU is never granted while fdd_req is held.

Source files
------------

// File: rtl/mem_arbiter.sv
// Sequential arbiter for the byte-wide SDRAM port: loader > FDD > CPU fixed priority.
// Latency: strobe one cycle after the IDLE grant, ack MEM_LAT+1 cycles after it; no preemption.
// Backpressure: level requests held until ack; ARB_STARVE_GUARD_EN forces a CPU grant after STARVE_MAX others.
module mem_arbiter #(
    parameter int         MEM_LAT    = 4,
    parameter logic [4:0] FDD_BASE   = 5'b00001,
    parameter int         STARVE_MAX = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ld_req,
    input  logic [24:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_ack,
    input  logic        fdd_req,
    input  logic [19:0] fdd_addr,
    output logic [7:0]  fdd_data,
    output logic        fdd_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [24:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_ready,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SRC_LD, SRC_FDD, SRC_CPU} src_t;

    // WAIT lasts MEM_LAT-1 cycles: counter runs from MEM_LAT-2 down to 0.
    localparam logic [3:0] WAIT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

    state_t      state_q, state_d;
    src_t        gnt_src_q, gnt_src_d;
    logic        gnt_we_q, gnt_we_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_din_q, mem_din_d;
    logic        mem_we_q, mem_we_d, mem_rd_q, mem_rd_d;
    logic        ld_ack_q, ld_ack_d, fdd_ack_q, fdd_ack_d, cpu_ack_q, cpu_ack_d;
    logic [7:0]  fdd_data_q, fdd_data_d, cpu_rdata_q, cpu_rdata_d;
    logic        force_cpu, grant, finish;

    always_comb begin
        state_d     = state_q;
        gnt_src_d   = gnt_src_q;
        gnt_we_d    = gnt_we_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = 1'b0;
        mem_rd_d    = 1'b0;
        ld_ack_d    = 1'b0;
        fdd_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        fdd_data_d  = fdd_data_q;
        cpu_rdata_d = cpu_rdata_q;
        grant       = 1'b0;
        finish      = 1'b0;
        case (state_q)
            IDLE: begin
                grant = 1'b1;
                if (force_cpu)    gnt_src_d = SRC_CPU;
                else if (ld_req)  gnt_src_d = SRC_LD;
                else if (fdd_req) gnt_src_d = SRC_FDD;
                else if (cpu_req) gnt_src_d = SRC_CPU;
                else              grant     = 1'b0;
                if (grant) begin
                    state_d = ISSUE;
                    case (gnt_src_d)
                        SRC_LD: begin
                            mem_addr_d = ld_addr;
                            mem_din_d  = ld_data;
                            gnt_we_d   = 1'b1;
                        end
                        SRC_FDD: begin
                            mem_addr_d = {FDD_BASE, fdd_addr};
                            gnt_we_d   = 1'b0;
                        end
                        default: begin
                            mem_addr_d = cpu_addr;
                            gnt_we_d   = cpu_we;
                            if (cpu_we) mem_din_d = cpu_wdata;
                        end
                    endcase
                    mem_we_d = gnt_we_d;
                    mem_rd_d = ~gnt_we_d;
                end
            end
            ISSUE: begin
                cnt_d = WAIT_INIT;
                if (MEM_LAT > 1) begin
                    state_d = WAIT;
                end else begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Ack and read data are registered on entry to DONE so both are visible there.
        if (finish) begin
            case (gnt_src_q)
                SRC_LD:  ld_ack_d = 1'b1;
                SRC_FDD: begin
                    fdd_ack_d  = 1'b1;
                    fdd_data_d = mem_dout;
                end
                default: begin
                    cpu_ack_d = 1'b1;
                    if (!gnt_we_q) cpu_rdata_d = mem_dout;
                end
            endcase
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    assign force_cpu = cpu_req && (starve_q == 4'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (!cpu_req)  starve_d = 4'd0;
        else if (grant) starve_d = (gnt_src_d == SRC_CPU) ? 4'd0 : starve_q + 4'd1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) starve_q <= 4'd0;
        else          starve_q <= starve_d;
    end
`else
    // Strict priority: STARVE_MAX has no effect in this build.
    assign force_cpu = 1'b0 && (STARVE_MAX > 0);
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_src_q   <= SRC_LD;
            gnt_we_q    <= 1'b0;
            cnt_q       <= 4'd0;
            mem_addr_q  <= 25'd0;
            mem_din_q   <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            ld_ack_q    <= 1'b0;
            fdd_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            fdd_data_q  <= 8'd0;
            cpu_rdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            gnt_src_q   <= gnt_src_d;
            gnt_we_q    <= gnt_we_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            mem_rd_q    <= mem_rd_d;
            ld_ack_q    <= ld_ack_d;
            fdd_ack_q   <= fdd_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            fdd_data_q  <= fdd_data_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = mem_we_q;
    assign mem_rd    = mem_rd_q;
    assign ld_ack    = ld_ack_q;
    assign fdd_ack   = fdd_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign fdd_data  = fdd_data_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = ~cpu_req | cpu_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected accesses (source, address, data, ack cycle)
// popped on each ack; SDRAM read data is a fixed function of the held address.
module tb_mem_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ld_req, fdd_req, cpu_req, cpu_we;
    logic [24:0] ld_addr, cpu_addr;
    logic [19:0] fdd_addr;
    logic [7:0]  ld_data, cpu_wdata;
    logic        ld_ack, fdd_ack, cpu_ack, cpu_ready;
    logic [7:0]  fdd_data, cpu_rdata, mem_din, mem_dout;
    logic [24:0] mem_addr;
    logic        mem_we, mem_rd;

    always #10 clk_sys = ~clk_sys;

    mem_arbiter dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .fdd_req(fdd_req), .fdd_addr(fdd_addr), .fdd_data(fdd_data), .fdd_ack(fdd_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_ready(cpu_ready),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout)
    );

    function automatic logic [7:0] dout_of(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hB8;
    endfunction
    assign mem_dout = dout_of(mem_addr);

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0]  src;   // 1 = loader, 2 = fdd, 3 = cpu
        logic        we;
        logic [24:0] addr;
        logic [7:0]  wd;
        int          at;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_acc(input logic [1:0] src, input logic we, input logic [24:0] addr,
                              input logic [7:0] wd, input int at);
        exp_t e;
        e.src = src; e.we = we; e.addr = addr; e.wd = wd; e.at = at;
        sb.push_back(e);
    endtask

    // Mark the current cycle (DUT in IDLE) as cycle 0 of a new access.
    task automatic next_cycle();
        @(posedge clk_sys); #1;
        cyc = 0;
    endtask

    task automatic run(input int budget, input bit hold_fdd, input int ready_at);
        exp_t e;
        logic [2:0] want;
        int c = 0;
        while (sb.size() > 0 && c < budget) begin
            @(posedge clk_sys); #1;
            c++; cyc++;
            if (ready_at >= 0) chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, cyc >= ready_at});
            if (mem_we || mem_rd) begin
                chk("strobe_addr", {7'd0, mem_addr}, {7'd0, sb[0].addr});
                chk("strobe_kind", {30'd0, mem_we, mem_rd}, {30'd0, sb[0].we, ~sb[0].we});
                if (sb[0].we) chk("strobe_din", {24'd0, mem_din}, {24'd0, sb[0].wd});
            end
            if (ld_ack || fdd_ack || cpu_ack) begin
                e = sb.pop_front();
                want = (e.src == 2'd1) ? 3'b100 : (e.src == 2'd2) ? 3'b010 : 3'b001;
                chk("ack_src", {29'd0, ld_ack, fdd_ack, cpu_ack}, {29'd0, want});
                chk("ack_cycle", cyc, e.at);
                if (!e.we)
                    chk("rdata", {24'd0, (e.src == 2'd2) ? fdd_data : cpu_rdata},
                        {24'd0, dout_of(e.addr)});
                case (e.src)
                    2'd1:    ld_req = 1'b0;
                    2'd2:    if (!hold_fdd) fdd_req = 1'b0;
                    default: cpu_req = 1'b0;
                endcase
            end
        end
        if (sb.size() != 0) begin
            chk("timeout_pending", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic ack_single();
        @(posedge clk_sys); #1;
        chk("ack_single", {29'd0, ld_ack, fdd_ack, cpu_ack}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        ld_req = 1'b0; fdd_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        ld_addr = '0; ld_data = '0; fdd_addr = '0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_strobes_acks", {27'd0, mem_we, mem_rd, ld_ack, fdd_ack, cpu_ack}, 32'd0);
        chk("rst_mem_addr", {7'd0, mem_addr}, 32'd0);
        chk("rst_rdata", {16'd0, fdd_data, cpu_rdata}, 32'd0);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);

        // CPU read, ready low until the ack cycle
        next_cycle();
        cpu_addr = 25'h00C123; cpu_we = 1'b0; cpu_req = 1'b1;
        #1 chk("ready_c0", {31'd0, cpu_ready}, 32'd0);
        expect_acc(2'd3, 1'b0, 25'h00C123, 8'h00, 5);
        run(20, 1'b0, 5);
        chk("t1_cpu_rdata", {24'd0, cpu_rdata}, 32'h5A);
        ack_single();

        // Loader write
        next_cycle();
        ld_addr = 25'h000100; ld_data = 8'hC3; ld_req = 1'b1;
        expect_acc(2'd1, 1'b1, 25'h000100, 8'hC3, 5);
        run(20, 1'b0, -1);
        ack_single();

        // FDD read with base prefix
        next_cycle();
        fdd_addr = 20'h00010; fdd_req = 1'b1;
        expect_acc(2'd2, 1'b0, 25'h0100010, 8'h00, 5);
        run(20, 1'b0, -1);
        chk("t3_fdd_data", {24'd0, fdd_data}, 32'hB8);
        ack_single();

        // All three at once: ld, fdd, cpu write in order
        next_cycle();
        ld_addr = 25'h000200; ld_data = 8'h11; fdd_addr = 20'h00ABC;
        cpu_addr = 25'h1234567; cpu_we = 1'b1; cpu_wdata = 8'h77;
        ld_req = 1'b1; fdd_req = 1'b1; cpu_req = 1'b1;
        expect_acc(2'd1, 1'b1, 25'h000200, 8'h11, 5);
        expect_acc(2'd2, 1'b0, 25'h0100ABC, 8'h00, 11);
        expect_acc(2'd3, 1'b1, 25'h1234567, 8'h77, 17);
        run(40, 1'b0, -1);
        chk("t4_cpu_rdata_kept", {24'd0, cpu_rdata}, 32'h5A);
        ack_single();

        // Reset in WAIT of a CPU read aborts it with no ack
        next_cycle();
        cpu_addr = 25'h0000F0; cpu_we = 1'b0; cpu_req = 1'b1;
        repeat (3) @(posedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_clear", {27'd0, mem_we, mem_rd, ld_ack, fdd_ack, cpu_ack}, 32'd0);
        chk("t5_rdata_cleared", {24'd0, cpu_rdata}, 32'd0);
        cpu_req = 1'b0;
        @(posedge clk_sys); #1 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_sys); #1;
            chk("t5_quiet", {27'd0, mem_we, mem_rd, ld_ack, fdd_ack, cpu_ack}, 32'd0);
        end
        next_cycle();
        cpu_req = 1'b1;
        expect_acc(2'd3, 1'b0, 25'h0000F0, 8'h00, 5);
        run(20, 1'b0, -1);
        ack_single();

        // FDD and CPU held together
        next_cycle();
        fdd_addr = 20'h00020; cpu_addr = 25'h000077; cpu_we = 1'b0;
        fdd_req = 1'b1; cpu_req = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) expect_acc(2'd2, 1'b0, 25'h0100020, 8'h00, 5 + 6 * i);
        expect_acc(2'd3, 1'b0, 25'h000077, 8'h00, 29);
        expect_acc(2'd2, 1'b0, 25'h0100020, 8'h00, 35);
        run(60, 1'b1, -1);
        fdd_req = 1'b0;
`else
        for (int i = 0; i < 6; i++) expect_acc(2'd2, 1'b0, 25'h0100020, 8'h00, 5 + 6 * i);
        run(60, 1'b1, -1);
        fdd_req = 1'b0;
        expect_acc(2'd3, 1'b0, 25'h000077, 8'h00, 41);
        run(20, 1'b0, -1);
`endif
        ack_single();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
